jk_cmd_sequencer: RTL and testbench
===================================

JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4: command FIFO depth; power of two, 2..16.
REQ-002 Parameter CNT_W, default 4: width of the per-command repeat count.
REQ-003 clk  input  1: single clock; all logic on posedge clk.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 cmd_valid  input  1: a command is offered.
REQ-006 cmd_ready  output  1: FIFO can accept a command; a command transfers when cmd_valid && cmd_ready at posedge clk.
REQ-007 cmd_op  input  2: operation code {J,K}: 00 hold, 01 reset, 10 set, 11 toggle.
REQ-008 cmd_cnt  input  CNT_W: repeat count; the op is driven for cmd_cnt+1 consecutive cycles.
REQ-009 q_in  input  1: Q fed back from the downstream JK flip-flop, which shares clk and rst.
REQ-010 J  output  1: registered J to the downstream flop.
REQ-011 K  output  1: registered K to the downstream flop.
REQ-012 busy  output  1: high when the sequencer is not IDLE or the FIFO is non-empty.
REQ-013 done  output  1: one-cycle pulse marking completion of each command.
REQ-014 err  output  1: sticky flag; set on any Q mismatch.

Function
REQ-015 FIFO SHALL be DEPTH entries of {op, cnt}; cmd_ready = !full, combinational from FIFO state only.
REQ-016 When full, a push SHALL be refused even if a pop occurs in the same cycle.
REQ-017 A push and a pop in the same cycle SHALL both take effect when the FIFO is neither full nor empty.
REQ-018 There is no empty-FIFO bypass: a command accepted at edge E0 SHALL be popped at E1, and J/K SHALL carry its op from E1.
REQ-019 FSM states SHALL be IDLE, DRIVE and CHECK.
REQ-020 IDLE: if the FIFO is non-empty, pop, load op, load remaining = cnt, and go to DRIVE; otherwise J=K=0.
REQ-021 DRIVE: J,K = op every cycle and remaining decrements each cycle; when remaining = 0, go to CHECK.
REQ-022 CHECK, one cycle: J=K=0, done=1, and q_in SHALL be compared to q_exp.
REQ-023 CHECK exit: pop and go to DRIVE if the FIFO is non-empty; otherwise go to IDLE.
REQ-024 q_exp: an internal model of the flop; each DRIVE cycle SHALL apply hold/reset/set/toggle to q_exp.
REQ-025 On mismatch in CHECK, err SHALL be set and held until rst; the mismatch SHALL NOT stall the sequencer.
REQ-026 The remaining counter SHALL never wrap: cnt = max (2^CNT_W-1) drives exactly 2^CNT_W cycles.
REQ-027 A hold command (00) SHALL still occupy cnt+1 DRIVE cycles plus a CHECK cycle.

Reset
REQ-028 rst SHALL set: J=0, K=0, done=0, err=0, busy=0, q_exp=0, FIFO empty, state IDLE.
REQ-029 rst mid-command SHALL abandon the command and the queued entries, with no done pulse.
REQ-030 cmd_ready SHALL be 1 in the cycle after rst deasserts.
REQ-031 A command offered while rst=1 SHALL NOT be accepted.

Structure
REQ-032 A shared package jk_pkg SHALL hold the op encodings (OP_HOLD, OP_RST, OP_SET, OP_TGL) and the FSM state enum.
REQ-033 The FIFO SHALL be a sub-module, sync_fifo, parameterised by width and depth.
REQ-034 The FSM, the counter and the q_exp model SHALL reside in jk_cmd_sequencer.

Verification (bench instantiates jk_cmd_sequencer driving a JK flip-flop, q_in = Q)
REQ-035 Push op=10, cnt=0 -> J=1,K=0 for 1 cycle after E1; done at E2; q_in=1; err=0.
REQ-036 Push op=11, cnt=2 from Q=0 -> 3 toggle cycles; CHECK sees q_in=1; err=0; done pulses exactly once.
REQ-037 Push 5 commands back-to-back with DEPTH=4 and no pops yet -> cmd_ready=0 after the 4th; 5th accepted only after the first pop.
REQ-038 Force q_in=0 during a set command -> err=1 in the cycle after CHECK and stays 1 through 3 further commands.
REQ-039 Assert rst mid-DRIVE of op=11, cnt=15 -> next cycle J=K=0, busy=0, FIFO empty, no done pulse.
REQ-040 op=00, cnt=15 -> exactly 16 DRIVE cycles with J=K=0, then done; Q unchanged.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared definitions for the JK command sequencer:
// op encodings, FSM states and the JK next-state helper.
package jk_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_RST  = 2'b01,
        OP_SET  = 2'b10,
        OP_TGL  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        CHECK = 2'b10
    } state_e;

    localparam int OP_W = 2;

    function automatic logic apply_op(input logic q, input op_e op);
        logic r;
        r = q;
        unique case (op)
            OP_HOLD: r = q;
            OP_RST:  r = 1'b0;
            OP_SET:  r = 1'b1;
            OP_TGL:  r = ~q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter.
// Head entry is visible combinationally on rdata.
module sync_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is 2^n.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Queues {op, cnt} commands and drives J/K to a downstream flop,
// tracking the expected Q and flagging mismatches at command end.
module jk_cmd_sequencer
    import jk_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             q_in,
    output logic             J,
    output logic             K,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int EW = OP_W + CNT_W;

    logic [EW-1:0]    wdata;
    logic [EW-1:0]    rdata;
    logic             full;
    logic             empty;
    logic             pop;
    op_e              head_op;
    logic [CNT_W-1:0] head_cnt;

    state_e           state;
    op_e              op;
    logic [CNT_W-1:0] remaining;
    logic             q_exp;

    assign wdata     = {cmd_op, cmd_cnt};
    assign head_op   = op_e'(rdata[CNT_W +: OP_W]);
    assign head_cnt  = rdata[CNT_W-1:0];
    assign cmd_ready = !full;
    assign pop       = !empty && (state == IDLE || state == CHECK);
    assign busy      = (state != IDLE) || !empty;

    sync_fifo #(
        .WIDTH(EW),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (cmd_valid),
        .wdata(wdata),
        .pop  (pop),
        .rdata(rdata),
        .full (full),
        .empty(empty)
    );

    // Sequencer FSM with registered J/K/done and the expected-Q model.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op        <= OP_HOLD;
            remaining <= '0;
            q_exp     <= 1'b0;
            J         <= 1'b0;
            K         <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    {J, K} <= 2'b00;
                    if (!empty) begin
                        op        <= head_op;
                        remaining <= head_cnt;
                        {J, K}    <= head_op;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    q_exp <= apply_op(q_exp, op);
                    if (remaining == '0) begin
                        {J, K} <= 2'b00;
                        done   <= 1'b1;
                        state  <= CHECK;
                    end else begin
                        remaining <= remaining - CNT_W'(1);
                        {J, K}    <= op;
                    end
                end
                CHECK: begin
                    if (q_in != q_exp) err <= 1'b1;
                    if (!empty) begin
                        op        <= head_op;
                        remaining <= head_cnt;
                        {J, K}    <= head_op;
                        state     <= DRIVE;
                    end else begin
                        {J, K} <= 2'b00;
                        state  <= IDLE;
                    end
                end
                default: begin
                    {J, K} <= 2'b00;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench: sequencer drives a JK flop whose Q feeds back.
// Expected values are hand-derived cycle by cycle.
module tb_jk_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic             q_in;
    logic             J;
    logic             K;
    logic             busy;
    logic             done;
    logic             err;
    logic             q;
    logic             force_q;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int base;
    int jk_cnt;
    int bad_jk;
    int bad_ready;

    logic [1:0]       ops  [4];
    logic [CNT_W-1:0] cnts [4];

    jk_cmd_sequencer #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_cnt  (cmd_cnt),
        .q_in     (q_in),
        .J        (J),
        .K        (K),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream JK flop sharing clk and rst.
    always_ff @(posedge clk) begin
        if (rst) q <= 1'b0;
        else begin
            case ({J, K})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign q_in = force_q ? 1'b0 : q;

    // Count done pulses mid-cycle.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag, input int max);
        int i;
        i = 0;
        while (busy && i < max) begin
            tick;
            i++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        ops[0] = 2'b01; cnts[0] = 4'd0;
        ops[1] = 2'b10; cnts[1] = 4'd0;
        ops[2] = 2'b11; cnts[2] = 4'd1;
        ops[3] = 2'b10; cnts[3] = 4'd0;

        // Reset, with a command offered during reset
        rst       = 1'b1;
        force_q   = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_cnt   = '0;
        tick;
        tick;
        chk("rst_j", 32'(J), 32'd0);
        chk("rst_k", 32'(K), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        tick;
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);
        chk("no_accept_in_rst", 32'(busy), 32'd0);

        // Set, cnt=0
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_cnt   = 4'd0;
        tick;
        cmd_valid = 1'b0;
        chk("set_e0_busy", 32'(busy), 32'd1);
        chk("set_no_bypass", 32'(J), 32'd0);
        tick;
        chk("set_e1_j", 32'(J), 32'd1);
        chk("set_e1_k", 32'(K), 32'd0);
        tick;
        chk("set_e2_j", 32'(J), 32'd0);
        chk("set_e2_done", 32'(done), 32'd1);
        chk("set_e2_q", 32'(q), 32'd1);
        tick;
        chk("set_e3_done", 32'(done), 32'd0);
        chk("set_e3_err", 32'(err), 32'd0);
        chk("set_e3_busy", 32'(busy), 32'd0);

        // Toggle, cnt=2, from Q=0
        rst = 1'b1;
        tick;
        rst = 1'b0;
        base      = done_cnt;
        jk_cnt    = 0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_cnt   = 4'd2;
        tick;
        cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (J && K) jk_cnt++;
        end
        chk("tgl_cycles", 32'(jk_cnt), 32'd3);
        chk("tgl_q", 32'(q), 32'd1);
        chk("tgl_err", 32'(err), 32'd0);
        chk("tgl_done_once", 32'(done_cnt - base), 32'd1);

        // Long hold keeps FIFO from draining; fill it
        base      = done_cnt;
        bad_jk    = 0;
        bad_ready = 0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_cnt   = 4'd15;
        tick;
        for (int i = 0; i < 4; i++) begin
            cmd_op  = ops[i];
            cmd_cnt = cnts[i];
            tick;
            if (J || K) bad_jk++;
        end
        chk("full_after_4", 32'(cmd_ready), 32'd0);
        cmd_op  = 2'b00;
        cmd_cnt = 4'd0;
        for (int k = 5; k <= 16; k++) begin
            tick;
            if (J || K) bad_jk++;
            if (cmd_ready) bad_ready++;
        end
        chk("hold_jk_zero", 32'(bad_jk), 32'd0);
        chk("full_held", 32'(bad_ready), 32'd0);
        chk("hold_not_early", 32'(done), 32'd0);
        tick;
        chk("hold_16_done", 32'(done), 32'd1);
        chk("hold_q", 32'(q), 32'd1);
        chk("hold_full", 32'(cmd_ready), 32'd0);
        tick;
        chk("full_refuse", 32'(cmd_ready), 32'd1);
        tick;
        chk("fifth_accept", 32'(cmd_ready), 32'd0);
        chk("c1_done", 32'(done), 32'd1);
        cmd_valid = 1'b0;
        wait_idle("queue_drain", 80);
        chk("queue_dones", 32'(done_cnt - base), 32'd6);
        chk("queue_q", 32'(q), 32'd1);
        chk("queue_err", 32'(err), 32'd0);

        // Forced mismatch during a set
        force_q   = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_cnt   = 4'd0;
        tick;
        cmd_valid = 1'b0;
        tick;
        tick;
        chk("mm_check_done", 32'(done), 32'd1);
        chk("mm_err_pre", 32'(err), 32'd0);
        tick;
        chk("mm_err_set", 32'(err), 32'd1);
        force_q   = 1'b0;
        base      = done_cnt;
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_cnt   = 4'd0;
        tick;
        cmd_op  = 2'b00;
        cmd_cnt = 4'd1;
        tick;
        cmd_op  = 2'b01;
        cmd_cnt = 4'd0;
        tick;
        cmd_valid = 1'b0;
        wait_idle("mm_drain", 40);
        chk("mm_no_stall", 32'(done_cnt - base), 32'd3);
        chk("mm_err_sticky", 32'(err), 32'd1);
        chk("mm_q", 32'(q), 32'd0);

        // Reset mid-drive with an entry queued
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_cnt   = 4'd15;
        tick;
        cmd_op  = 2'b10;
        cmd_cnt = 4'd0;
        tick;
        cmd_valid = 1'b0;
        tick;
        tick;
        tick;
        chk("mid_drive_jk", 32'({J, K}), 32'd3);
        base = done_cnt;
        rst  = 1'b1;
        tick;
        rst  = 1'b0;
        chk("mrst_j", 32'(J), 32'd0);
        chk("mrst_k", 32'(K), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ready", 32'(cmd_ready), 32'd1);
        chk("mrst_err", 32'(err), 32'd0);
        for (int i = 0; i < 6; i++) tick;
        chk("mrst_still_idle", 32'(busy), 32'd0);
        chk("mrst_no_done", 32'(done_cnt - base), 32'd0);
        chk("mrst_q", 32'(q), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
